// File: rtl/decoder_onehot_seq.sv
// -----------------------------------------------------------------------------
// decoder_onehot_seq
//
// Registered IN_W-to-2**IN_W one-hot decoder with a valid/ready request port
// and three output modes:
//   static (mode 00, and reserved 11): hold 1<<in_sel until the next request
//   pulse  (mode 01): drive 1<<in_sel for PULSE_LEN cycles, then clear
//   scan   (mode 10): starting at in_sel, walk the hot bit through every output,
//                     SCAN_DWELL cycles per output, wrapping at the top, then
//                     clear
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   request valid
//   in_ready   request can be accepted (equals !busy)
//   in_sel     output index to decode, captured on accept
//   mode       output mode, captured on accept
//   out        decoded output (registered)
//   out_valid  out currently holds a decoded value
//   busy       a pulse or scan sequence is in progress
//
// Build option: define DECODER_ONEHOT_SEQ_ACTLOW_EN to make out one-cold
// (bitwise inverse of the internal one-hot, all-ones in reset). out_valid,
// busy and in_ready are unaffected.
// -----------------------------------------------------------------------------
module decoder_onehot_seq #(
    parameter int IN_W       = 2,
    parameter int PULSE_LEN  = 4,
    parameter int SCAN_DWELL = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_sel,
    input  logic [1:0]           mode,
    output logic [2**IN_W-1:0]   out,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int OUT_W = 2**IN_W;

    localparam logic [7:0]      PULSE_RLD = 8'(PULSE_LEN - 1);
    localparam logic [7:0]      DWELL_RLD = 8'(SCAN_DWELL - 1);
    localparam logic [IN_W-1:0] STEPS_RLD = IN_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STATIC,
        S_PULSE,
        S_SCAN
    } state_t;

    state_t            state_q, state_nxt;
    logic [OUT_W-1:0]  onehot_q, onehot_nxt;
    logic              out_valid_q, out_valid_nxt;
    logic              busy_q, busy_nxt;
    logic [7:0]        cnt_q, cnt_nxt;
    logic [7:0]        dwell_q, dwell_nxt;
    logic [IN_W-1:0]   idx_q, idx_nxt;
    logic [IN_W-1:0]   steps_q, steps_nxt;
    logic [IN_W-1:0]   idx_inc;
    logic              accept;

    function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] s);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    assign in_ready = !busy_q;
    assign accept   = in_valid && in_ready;
    // Natural IN_W-bit overflow gives the OUT_W-1 -> 0 wrap.
    assign idx_inc  = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            onehot_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            idx_q       <= '0;
            steps_q     <= '0;
        end else begin
            state_q     <= state_nxt;
            onehot_q    <= onehot_nxt;
            out_valid_q <= out_valid_nxt;
            busy_q      <= busy_nxt;
            cnt_q       <= cnt_nxt;
            dwell_q     <= dwell_nxt;
            idx_q       <= idx_nxt;
            steps_q     <= steps_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        onehot_nxt    = onehot_q;
        out_valid_nxt = out_valid_q;
        busy_nxt      = busy_q;
        cnt_nxt       = cnt_q;
        dwell_nxt     = dwell_q;
        idx_nxt       = idx_q;
        steps_nxt     = steps_q;

        case (state_q)
            S_IDLE, S_STATIC: begin
                if (accept) begin
                    onehot_nxt    = decode(in_sel);
                    out_valid_nxt = 1'b1;
                    case (mode)
                        2'b01: begin
                            state_nxt = S_PULSE;
                            busy_nxt  = 1'b1;
                            cnt_nxt   = PULSE_RLD;
                        end
                        2'b10: begin
                            state_nxt = S_SCAN;
                            busy_nxt  = 1'b1;
                            idx_nxt   = in_sel;
                            steps_nxt = STEPS_RLD;
                            dwell_nxt = DWELL_RLD;
                        end
                        default: state_nxt = S_STATIC;
                    endcase
                end
            end
            S_PULSE: begin
                if (cnt_q != 8'd0) begin
                    cnt_nxt = cnt_q - 8'd1;
                end else begin
                    state_nxt     = S_IDLE;
                    onehot_nxt    = '0;
                    out_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                end
            end
            S_SCAN: begin
                if (dwell_q != 8'd0) begin
                    dwell_nxt = dwell_q - 8'd1;
                end else if (steps_q != '0) begin
                    idx_nxt    = idx_inc;
                    onehot_nxt = decode(idx_inc);
                    steps_nxt  = steps_q - 1'b1;
                    dwell_nxt  = DWELL_RLD;
                end else begin
                    state_nxt     = S_IDLE;
                    onehot_nxt    = '0;
                    out_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef DECODER_ONEHOT_SEQ_ACTLOW_EN
    assign out = ~onehot_q;
`else
    assign out = onehot_q;
`endif

    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
